// File: rtl/cnn_pkg.sv
// Shared definitions for the line-buffer controller: FSM encoding and row counter width.
package cnn_pkg;

    localparam int unsigned ROW_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } lbc_state_t;

endpackage

// File: rtl/lbc_out_pipe.sv
// Two-stage output pipeline: stage 1 pairs the accepted pixel with the
// same-address memory read, stage 2 is the m_* output register.
module lbc_out_pipe #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_zero,
    input  logic [DATA_WIDTH-1:0] in_cur,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  s1_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_prev,
    output logic [DATA_WIDTH-1:0] m_cur
);

    logic                  s1_fresh;
    logic                  s1_zero;
    logic [DATA_WIDTH-1:0] s1_cur;
    logic [DATA_WIDTH-1:0] s1_prev;
    logic [DATA_WIDTH-1:0] prev_c;
    logic                  s2_free;

    // mem_dout is only valid the cycle after the read; afterwards use the captured copy
    always_comb begin
        s2_free = !m_valid || m_ready;
        prev_c  = s1_prev;
        if (s1_zero) begin
            prev_c = '0;
        end else if (s1_fresh) begin
            prev_c = mem_dout;
        end
    end

    // Stage 1: load on accept, drain into stage 2, or freeze the read data while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
            s1_zero  <= 1'b0;
            s1_cur   <= '0;
            s1_prev  <= '0;
        end else if (in_valid) begin
            s1_valid <= 1'b1;
            s1_fresh <= 1'b1;
            s1_zero  <= in_zero;
            s1_cur   <= in_cur;
        end else if (s1_valid && s2_free) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
        end else if (s1_valid) begin
            s1_prev  <= prev_c;
            s1_fresh <= 1'b0;
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_prev  <= '0;
            m_cur   <= '0;
        end else if (s2_free) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_prev <= prev_c;
                m_cur  <= s1_cur;
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Single-line buffer controller: writes each row into memory while reading back
// the pixel one row above at the same column.
// Optional build macro LINE_BUF_CTRL_ZERO_PAD_EN: row 0 is also emitted, with m_prev=0.
module line_buf_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] cfg_row_len,
    input  logic [ROW_CNT_W-1:0]  cfg_rows,
    output logic                  cfg_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_prev,
    output logic [DATA_WIDTH-1:0] m_cur,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned AW = ADDR_WIDTH;

    lbc_state_t           state;
    lbc_state_t           state_d;
    logic                 done_d;
    logic                 cfg_err_d;
    logic [AW-1:0]        row_len;
    logic [AW-1:0]        col;
    logic [ROW_CNT_W-1:0] rows;
    logic [ROW_CNT_W-1:0] row;
    logic                 in_done;
    logic                 s1_valid;
    logic                 cfg_bad;
    logic                 start_ok;
    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic                 emit;
    logic                 final_xfer;

    // Handshake, position decode and memory port drive
    always_comb begin
        busy        = (state != ST_IDLE);
        cfg_bad     = (cfg_row_len == '0) || (cfg_rows == '0);
        start_ok    = (state == ST_IDLE) && start && !cfg_bad;
        s_ready     = busy && !in_done && !(s1_valid && m_valid && !m_ready);
        accept      = s_valid && s_ready;
        last_col    = (col == row_len - AW'(1));
        last_row    = (row == rows - ROW_CNT_W'(1));
`ifdef LINE_BUF_CTRL_ZERO_PAD_EN
        emit        = busy;
`else
        emit        = (state == ST_STREAM);
`endif
        final_xfer  = in_done && !s1_valid && m_valid && m_ready;
        mem_we      = accept;
        mem_wr_addr = col;
        mem_rd_addr = col;
        mem_din     = accept ? s_data : '0;
    end

    // Next-state and pulse outputs
    always_comb begin
        state_d   = state;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (accept && last_col && !last_row) begin
                    state_d = ST_STREAM;
                end
`ifdef LINE_BUF_CTRL_ZERO_PAD_EN
                if (final_xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
`else
                if (accept && last_col && last_row) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
            ST_STREAM: begin
                if (final_xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_d;
            done    <= done_d;
            cfg_err <= cfg_err_d;
        end
    end

    // Frame configuration latch and column/row counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_len <= '0;
            rows    <= '0;
            col     <= '0;
            row     <= '0;
            in_done <= 1'b0;
        end else if (start_ok) begin
            row_len <= cfg_row_len;
            rows    <= cfg_rows;
            col     <= '0;
            row     <= '0;
            in_done <= 1'b0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= row + ROW_CNT_W'(1);
                if (last_row) begin
                    in_done <= 1'b1;
                end
            end else begin
                col <= col + AW'(1);
            end
        end
    end

    lbc_out_pipe #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (accept && emit),
        .in_zero  (state == ST_FILL),
        .in_cur   (s_data),
        .mem_dout (mem_dout),
        .s1_valid (s1_valid),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_prev   (m_prev),
        .m_cur    (m_cur)
    );

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Testbench for line_buf_ctrl with a read-first memory and a queue-based frame model.
module tb_line_buf_ctrl;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 15;

    logic          clk;
    logic          reset;
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] cfg_row_len;
    logic [15:0]   cfg_rows;
    logic          cfg_err;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_prev;
    logic [DW-1:0] m_cur;
    logic          mem_we;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_dout;

    line_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_prev(m_prev), .m_cur(m_cur),
        .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
        .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first memory, one-cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial mem_dout = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_wr_addr] <= mem_din;
        mem_dout <= mem[mem_rd_addr];
    end

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pix[$];
    logic [DW-1:0] exp_prev[$];
    logic [DW-1:0] exp_cur[$];
    logic [DW-1:0] got_prev[$];
    logic [DW-1:0] got_cur[$];
    int  acc_cyc[$];
    int  xfer_cyc[$];
    int  done_cyc[$];
    int  addr_err;
    int  wrap_seen;
    int  ready_viol;
    int  first_mv;
    bit  timed_out;
    bit  zp;

    // Expected outputs from the frame rules: row r>0 pairs pixel (r-1,c) with (r,c)
    task automatic build_exp(input int len, input int rows);
        exp_prev.delete();
        exp_cur.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len; c++) begin
                if (r == 0) begin
                    if (zp) begin
                        exp_prev.push_back(DW'(0));
                        exp_cur.push_back(pix[c]);
                    end
                end else begin
                    exp_prev.push_back(pix[(r-1)*len + c]);
                    exp_cur.push_back(pix[r*len + c]);
                end
            end
        end
    endtask

    // Drive one frame of pix[], recording observations (no comparisons here)
    task automatic run_frame(input int len, input int rows, input int rmode,
                             input int vmode, input int stop_acc, input bit noise);
        int n, idx, cyc, budget, last_addr;
        bit fin;
        got_prev.delete(); got_cur.delete();
        acc_cyc.delete(); xfer_cyc.delete(); done_cyc.delete();
        addr_err = 0; wrap_seen = 0; ready_viol = 0; first_mv = -1; timed_out = 0;
        n = len * rows; idx = 0; cyc = 0; budget = n * 8 + 64; last_addr = -1; fin = 0;
        @(negedge clk);
        cfg_row_len = AW'(len);
        cfg_rows    = 16'(rows);
        start       = 1'b1;
        s_valid     = 1'b0;
        m_ready     = 1'b1;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            start = 1'b0;
            if (noise && idx < n) begin
                start       = ($urandom_range(0, 7) == 0);
                cfg_row_len = AW'($urandom);
                cfg_rows    = 16'($urandom);
            end
            s_valid = (idx < n) && (vmode == 0 || $urandom_range(0, 3) != 0);
            if (s_valid) s_data = pix[idx];
            else         s_data = DW'($urandom);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (s_valid && s_ready) begin
                if (mem_we !== 1'b1 || mem_wr_addr !== AW'(idx % len) ||
                    mem_rd_addr !== AW'(idx % len) || mem_din !== pix[idx]) addr_err++;
                if (last_addr == len - 1 && mem_wr_addr == '0) wrap_seen++;
                last_addr = int'(mem_wr_addr);
                acc_cyc.push_back(cyc);
                idx++;
            end else if (mem_we !== 1'b0) begin
                addr_err++;
            end
            if (busy && idx < n && !s_ready && !(m_valid && !m_ready)) ready_viol++;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                got_prev.push_back(m_prev);
                got_cur.push_back(m_cur);
                xfer_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                fin = 1;
            end
            if (stop_acc > 0 && idx >= stop_acc) fin = 1;
            cyc++;
        end
        if (!fin) timed_out = 1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        cfg_row_len = '0; cfg_rows = '0;
        #12;
        checks++;
        if ({s_ready, m_valid, mem_we, done, cfg_err, busy} !== 6'b0 ||
            m_prev !== '0 || m_cur !== '0 || mem_wr_addr !== '0 ||
            mem_rd_addr !== '0 || mem_din !== '0) begin
            failures++;
            $display("FAIL reset_state ctl=%b prev=%0d cur=%0d wa=%0d ra=%0d din=%0d required all zero",
                     {s_ready, m_valid, mem_we, done, cfg_err, busy}, m_prev, m_cur,
                     mem_wr_addr, mem_rd_addr, mem_din);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int emit_start, exp_done;
        pix.delete();
        for (int i = 1; i <= 12; i++) pix.push_back(DW'(i));
        build_exp(4, 3);
        run_frame(4, 3, 0, 0, 0, 0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout done=%0d required 1", 0); end
        checks++;
        if (got_cur.size() != exp_cur.size()) begin
            failures++; $display("FAIL basic_count got=%0d required=%0d", got_cur.size(), exp_cur.size());
        end
        for (int i = 0; i < exp_cur.size() && i < got_cur.size(); i++) begin
            checks++;
            if (got_prev[i] !== exp_prev[i] || got_cur[i] !== exp_cur[i]) begin
                failures++;
                $display("FAIL basic_out[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_prev[i], got_cur[i], exp_prev[i], exp_cur[i]);
            end
        end
        checks++;
        if (addr_err != 0) begin failures++; $display("FAIL basic_mem_ports errors=%0d required=0", addr_err); end
        emit_start = zp ? 0 : 4;
        checks++;
        if (acc_cyc.size() <= emit_start || first_mv != acc_cyc[emit_start] + 2) begin
            failures++;
            $display("FAIL basic_latency first_m_valid=%0d required=accept+2", first_mv);
        end
        exp_done = (xfer_cyc.size() > 0) ? xfer_cyc[$] + 1 : -100;
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
            failures++;
            $display("FAIL basic_done cycle=%0d required=%0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_after_done done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        pix.delete();
        for (int i = 1; i <= 12; i++) pix.push_back(DW'(i));
        build_exp(4, 3);
        run_frame(4, 3, 1, 0, 0, 0);
        checks++;
        if (timed_out || got_cur.size() != exp_cur.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d required=%0d timeout=%0d", got_cur.size(), exp_cur.size(), timed_out);
        end
        for (int i = 0; i < exp_cur.size() && i < got_cur.size(); i++) begin
            checks++;
            if (got_prev[i] !== exp_prev[i] || got_cur[i] !== exp_cur[i]) begin
                failures++;
                $display("FAIL bp_out[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_prev[i], got_cur[i], exp_prev[i], exp_cur[i]);
            end
        end
        checks++;
        if (ready_viol != 0) begin failures++; $display("FAIL bp_s_ready_low cycles=%0d required=0", ready_viol); end
        checks++;
        if (addr_err != 0) begin failures++; $display("FAIL bp_mem_ports errors=%0d required=0", addr_err); end
    endtask

    task automatic test_cfg_err();
        int bad_we;
        for (int k = 0; k < 2; k++) begin
            bad_we = 0;
            @(negedge clk);
            cfg_row_len = (k == 0) ? AW'(0) : AW'(4);
            cfg_rows    = (k == 0) ? 16'd3 : 16'd0;
            start = 1'b1; s_valid = 1'b1; s_data = DW'(99);
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL cfg_err_pulse[%0d] cfg_err=%b busy=%b required 1 0", k, cfg_err, busy);
            end
            for (int c = 0; c < 4; c++) begin
                if (mem_we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) bad_we++;
                @(negedge clk);
                #1;
            end
            checks++;
            if (bad_we != 0 || cfg_err !== 1'b0) begin
                failures++; $display("FAIL cfg_err_idle[%0d] bad_cycles=%0d cfg_err=%b required 0 0", k, bad_we, cfg_err);
            end
            s_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        pix.delete();
        for (int i = 1; i <= 12; i++) pix.push_back(DW'(i));
        run_frame(4, 3, 0, 0, 6, 0);
        checks++;
        if (m_valid !== 1'b1 || m_prev !== DW'(1) || m_cur !== DW'(5)) begin
            failures++; $display("FAIL pre_reset_out got=(%0d,%0d) v=%b required=(1,5) v=1", m_prev, m_cur, m_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, mem_we, done, cfg_err, busy} !== 6'b0 ||
            m_prev !== '0 || m_cur !== '0 || mem_wr_addr !== '0 ||
            mem_rd_addr !== '0 || mem_din !== '0) begin
            failures++;
            $display("FAIL midframe_reset ctl=%b prev=%0d cur=%0d wa=%0d ra=%0d required all zero",
                     {s_ready, m_valid, mem_we, done, cfg_err, busy}, m_prev, m_cur, mem_wr_addr, mem_rd_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        pix.delete();
        for (int i = 7; i <= 10; i++) pix.push_back(DW'(i));
        build_exp(2, 2);
        run_frame(2, 2, 0, 0, 0, 0);
        n = got_cur.size();
        checks++;
        if (timed_out || n != exp_cur.size()) begin
            failures++; $display("FAIL restart_count got=%0d required=%0d", n, exp_cur.size());
        end
        for (int i = 0; i < exp_cur.size() && i < n; i++) begin
            checks++;
            if (got_prev[i] !== exp_prev[i] || got_cur[i] !== exp_cur[i]) begin
                failures++;
                $display("FAIL restart_out[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_prev[i], got_cur[i], exp_prev[i], exp_cur[i]);
            end
        end
        checks++;
        if (n < 2 || got_prev[n-2] !== DW'(7) || got_cur[n-2] !== DW'(9) ||
            got_prev[n-1] !== DW'(8) || got_cur[n-1] !== DW'(10)) begin
            failures++; $display("FAIL restart_tail outputs=%0d required tail (7,9),(8,10)", n);
        end
    endtask

    task automatic test_wide_row();
        int errs;
        pix.delete();
        for (int i = 0; i < 2 * 16384; i++) pix.push_back(DW'($urandom));
        build_exp(16384, 2);
        run_frame(16384, 2, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_cur.size() != exp_cur.size()) begin
            failures++; $display("FAIL wide_count got=%0d required=%0d", got_cur.size(), exp_cur.size());
        end
        errs = 0;
        for (int i = 0; i < exp_cur.size() && i < got_cur.size(); i++) begin
            checks++;
            if (got_prev[i] !== exp_prev[i] || got_cur[i] !== exp_cur[i]) begin
                failures++;
                if (errs < 5) $display("FAIL wide_out[%0d] got=(%0h,%0h) required=(%0h,%0h)",
                                       i, got_prev[i], got_cur[i], exp_prev[i], exp_cur[i]);
                errs++;
            end
        end
        checks++;
        if (wrap_seen != 1 || addr_err != 0) begin
            failures++; $display("FAIL wide_addr_wrap wraps=%0d errors=%0d required 1 0", wrap_seen, addr_err);
        end
    endtask

    task automatic test_random();
        int len, rows, exp_done;
        for (int f = 0; f < 5; f++) begin
            len  = $urandom_range(1, 6);
            rows = $urandom_range(1, 4);
            pix.delete();
            for (int i = 0; i < len * rows; i++) pix.push_back(DW'($urandom));
            build_exp(len, rows);
            run_frame(len, rows, 2, 1, 0, 1);
            checks++;
            if (timed_out || got_cur.size() != exp_cur.size()) begin
                failures++;
                $display("FAIL rand%0d_count len=%0d rows=%0d got=%0d required=%0d",
                         f, len, rows, got_cur.size(), exp_cur.size());
            end
            for (int i = 0; i < exp_cur.size() && i < got_cur.size(); i++) begin
                checks++;
                if (got_prev[i] !== exp_prev[i] || got_cur[i] !== exp_cur[i]) begin
                    failures++;
                    $display("FAIL rand%0d_out[%0d] got=(%0h,%0h) required=(%0h,%0h)",
                             f, i, got_prev[i], got_cur[i], exp_prev[i], exp_cur[i]);
                end
            end
            exp_done = ((xfer_cyc.size() > 0) ? xfer_cyc[$] : ((acc_cyc.size() > 0) ? acc_cyc[$] : -100)) + 1;
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != exp_done || addr_err != 0 || ready_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_done_ports done=%0d required=%0d mem_err=%0d ready_err=%0d",
                         f, (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done, addr_err, ready_viol);
            end
        end
    endtask

`ifdef LINE_BUF_CTRL_ZERO_PAD_EN
    task automatic test_zero_pad();
        logic [DW-1:0] want_prev [4];
        logic [DW-1:0] want_cur  [4];
        want_prev = '{DW'(0), DW'(0), DW'(1), DW'(2)};
        want_cur  = '{DW'(1), DW'(2), DW'(3), DW'(4)};
        pix.delete();
        for (int i = 1; i <= 4; i++) pix.push_back(DW'(i));
        run_frame(2, 2, 0, 0, 0, 0);
        checks++;
        if (timed_out || got_cur.size() != 4) begin
            failures++; $display("FAIL zp_count got=%0d required=4", got_cur.size());
        end
        for (int i = 0; i < 4 && i < got_cur.size(); i++) begin
            checks++;
            if (got_prev[i] !== want_prev[i] || got_cur[i] !== want_cur[i]) begin
                failures++;
                $display("FAIL zp_out[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                         i, got_prev[i], got_cur[i], want_prev[i], want_cur[i]);
            end
        end
    endtask
`endif

    initial begin
`ifdef LINE_BUF_CTRL_ZERO_PAD_EN
        zp = 1'b1;
`else
        zp = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_reset_midframe();
`ifdef LINE_BUF_CTRL_ZERO_PAD_EN
        test_zero_pad();
`endif
        test_random();
        test_wide_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
